// File: rtl/fixed_stream_pkg.sv
// ============================================================================
//  Module      : fixed_stream_pkg
//  Description : Shared types and helpers for the fixed-point stream
//                roller/unroller pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fixed_stream_pkg;

  // Per-bank occupancy: FILL while beats are being written, HOLD while the
  // assembled vector waits for the consumer.
  typedef enum logic {
    BANK_FILL = 1'b0,
    BANK_HOLD = 1'b1
  } bank_state_t;

  // Width of the beat counter; never narrower than one bit so a ratio of 1
  // still yields a legal vector.
  function automatic int calc_cnt_w(input int ratio);
    if (ratio <= 1) begin
      return 1;
    end
    return $clog2(ratio);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_unroller_bank.sv
// ============================================================================
//  Module      : unroller_bank
//  Description : One OUT_NUM-lane vector register. Writes one IN_NUM-lane
//                group per accepted beat, zero-fills the groups above the
//                written one when a vector closes early, and tracks its own
//                FILL/HOLD state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unroller_bank
  import fixed_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 1,
  parameter int OUT_NUM    = 4,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [CNT_W-1:0]      i_wr_grp,
  input  logic [DATA_WIDTH-1:0] i_wr_data [IN_NUM],
  input  logic                  i_complete,
  input  logic                  i_rd_ack,
  output bank_state_t           o_state,
  output logic [DATA_WIDTH-1:0] o_data [OUT_NUM]
);

  localparam int RATIO = OUT_NUM / IN_NUM;

  bank_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_data [OUT_NUM];

  // Lane-group write, early-completion zero fill and FILL/HOLD tracking.
  // A read ack and a write may coincide: the held vector leaves and the new
  // beat lands in group 0 of the next one (HOLD again if that beat completes).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BANK_FILL;
      for (int l = 0; l < OUT_NUM; l++) begin
        r_data[l] <= '0;
      end
    end else begin
      if ((r_state == BANK_HOLD) && i_rd_ack) begin
        r_state <= BANK_FILL;
      end
      if (i_wr_en) begin
        for (int g = 0; g < RATIO; g++) begin
          for (int j = 0; j < IN_NUM; j++) begin
            if (CNT_W'(g) == i_wr_grp) begin
              r_data[g*IN_NUM + j] <= i_wr_data[j];
            end else if (i_complete && (CNT_W'(g) > i_wr_grp)) begin
              r_data[g*IN_NUM + j] <= '0;
            end
          end
        end
        if (i_complete) begin
          r_state <= BANK_HOLD;
        end
      end
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/fixed_unroller.sv
// ============================================================================
//  Module      : fixed_unroller
//  Description : Re-packs IN_NUM-lane beats into OUT_NUM-lane vectors,
//                lane 0 first, with valid/ready on both sides. data_in_last
//                closes a vector early (upper lanes zero).
//                Optional macro UNROLLER_DOUBLE_BUFFER_EN selects two banks
//                with write/read pointers to absorb output back-pressure;
//                otherwise a single bank is used.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_unroller
  import fixed_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 1,
  parameter int OUT_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic                  data_in_last,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int RATIO = OUT_NUM / IN_NUM;
  localparam int CNT_W = calc_cnt_w(RATIO);

  if ((OUT_NUM % IN_NUM) != 0) begin : g_bad_ratio
    $error("fixed_unroller: OUT_NUM (%0d) must be a multiple of IN_NUM (%0d)", OUT_NUM, IN_NUM);
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_complete;

  assign w_in_fire  = data_in_valid && data_in_ready;
  assign w_out_fire = data_out_valid && data_out_ready;
  assign w_complete = data_in_last || (r_cnt == CNT_W'(RATIO - 1));

  // Beat counter: selects the lane group and restarts after every vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
    end
  end

`ifdef UNROLLER_DOUBLE_BUFFER_EN
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  bank_state_t           w_state0;
  bank_state_t           w_state1;
  logic [DATA_WIDTH-1:0] w_bank0_data [OUT_NUM];
  logic [DATA_WIDTH-1:0] w_bank1_data [OUT_NUM];
  bank_state_t           w_wr_state;
  bank_state_t           w_rd_state;

  unroller_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_NUM     (IN_NUM),
    .OUT_NUM    (OUT_NUM),
    .CNT_W      (CNT_W)
  ) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_in_fire && !r_wr_ptr),
    .i_wr_grp   (r_cnt),
    .i_wr_data  (data_in),
    .i_complete (w_complete),
    .i_rd_ack   (w_out_fire && !r_rd_ptr),
    .o_state    (w_state0),
    .o_data     (w_bank0_data)
  );

  unroller_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_NUM     (IN_NUM),
    .OUT_NUM    (OUT_NUM),
    .CNT_W      (CNT_W)
  ) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_in_fire && r_wr_ptr),
    .i_wr_grp   (r_cnt),
    .i_wr_data  (data_in),
    .i_complete (w_complete),
    .i_rd_ack   (w_out_fire && r_rd_ptr),
    .o_state    (w_state1),
    .o_data     (w_bank1_data)
  );

  // Write pointer advances per completed vector, read pointer per handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_in_fire && w_complete) begin
        r_wr_ptr <= !r_wr_ptr;
      end
      if (w_out_fire) begin
        r_rd_ptr <= !r_rd_ptr;
      end
    end
  end

  assign w_wr_state     = r_wr_ptr ? w_state1 : w_state0;
  assign w_rd_state     = r_rd_ptr ? w_state1 : w_state0;
  assign data_in_ready  = (w_wr_state == BANK_FILL);
  assign data_out_valid = (w_rd_state == BANK_HOLD);

  // Present the bank addressed by the read pointer.
  always_comb begin
    for (int l = 0; l < OUT_NUM; l++) begin
      data_out[l] = r_rd_ptr ? w_bank1_data[l] : w_bank0_data[l];
    end
  end
`else
  bank_state_t w_state0;

  unroller_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_NUM     (IN_NUM),
    .OUT_NUM    (OUT_NUM),
    .CNT_W      (CNT_W)
  ) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_in_fire),
    .i_wr_grp   (r_cnt),
    .i_wr_data  (data_in),
    .i_complete (w_complete),
    .i_rd_ack   (w_out_fire),
    .o_state    (w_state0),
    .o_data     (data_out)
  );

  // A held vector blocks input unless it is leaving this same cycle.
  assign data_out_valid = (w_state0 == BANK_HOLD);
  assign data_in_ready  = !data_out_valid || data_out_ready;
`endif

endmodule

`default_nettype wire
